// File: rtl/alu_ops_pkg.sv
// Shared definitions for the ALU scheduler.
//   - opcode constants in the datapath's select order (ADD=0 .. DIV=9)
//   - scheduler state enum
//   - opcode classification helpers
package alu_ops_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LSR  = 4'd5;
  localparam logic [3:0] OP_LSL  = 4'd6;
  localparam logic [3:0] OP_MOD  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MOD) || (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_DIV;
  endfunction

  // opcodes that require a non-zero divisor
  function automatic logic needs_divisor(input logic [3:0] op);
    return (op == OP_MOD) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request vector (bit 0 = A, bit 1 = B)
//   en         : arbitration enabled this cycle; a grant is a handshake
//   gnt[1:0]   : one-hot grant (combinational), zero when en is low
// last_grant resets to B so that A wins the first contest.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant; // 0 = A, 1 = B

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (|gnt)   last_grant <= gnt[1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between requesters A and B.
//   clk, rst_n           : clock, async active-low reset
//   a_/b_valid, _ready   : request handshake (ready combinational, IDLE only)
//   a_/b_op, _x, _y      : opcode and operands, sampled at handshake
//   alu_sel, alu_a/b     : ALU drive, held at last accepted op's values
//   alu_res              : ALU combinational result
//   res_valid/id/y/err   : one-cycle tagged result pulse
// Rejected ops (illegal opcode, MOD/DIV by zero) skip the ALU entirely and
// leave alu_sel/alu_a/alu_b untouched.
module alu_scheduler
  import alu_ops_pkg::*;
#(
  parameter int N         = 4,
  parameter int MULTI_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [3:0]   a_op,
  input  logic [N-1:0] a_x,
  input  logic [N-1:0] a_y,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [3:0]   b_op,
  input  logic [N-1:0] b_x,
  input  logic [N-1:0] b_y,
  output logic [3:0]   alu_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_res,
  output logic         res_valid,
  output logic         res_id,
  output logic [N-1:0] res_y,
  output logic         res_err
);

  localparam int CW = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          hs;
  logic [3:0]    sel_op;
  logic [N-1:0]  sel_x, sel_y;
  logic          reject;

  // ready is forced low while reset is held, even though state is IDLE
  assign arb_en = (state == IDLE) && rst_n;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_valid, a_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign hs      = |gnt;

  assign sel_op = gnt[1] ? b_op : a_op;
  assign sel_x  = gnt[1] ? b_x  : a_x;
  assign sel_y  = gnt[1] ? b_y  : a_y;
  assign reject = !is_legal(sel_op) || (needs_divisor(sel_op) && (sel_y == '0));

  assign res_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = reject ? RESP : EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      res_id  <= 1'b0;
      res_y   <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hs) begin
            res_id <= gnt[1];
            if (reject) begin
              res_err <= 1'b1;
              res_y   <= '0;
            end else begin
              res_err <= 1'b0;
              alu_sel <= sel_op;
              alu_a   <= sel_x;
              alu_b   <= sel_y;
              cnt     <= is_multicycle(sel_op) ? CW'(MULTI_LAT - 1) : '0;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) res_y <= alu_res;
          else           cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler (N=4, MULTI_LAT=4) with a behavioural ALU.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_scheduler;
  localparam int N = 4;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
  logic [3:0]   a_op, b_op;
  logic [N-1:0] a_x, a_y, b_x, b_y;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_a, alu_b, alu_res;
  logic         res_valid, res_id, res_err;
  logic [N-1:0] res_y;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.N(N), .MULTI_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .res_valid(res_valid), .res_id(res_id), .res_y(res_y), .res_err(res_err)
  );

  // behavioural ALU, truncating to N bits
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'd0: alu_res = alu_a + alu_b;
      4'd1: alu_res = alu_a - alu_b;
      4'd2: alu_res = alu_a & alu_b;
      4'd3: alu_res = alu_a | alu_b;
      4'd4: alu_res = alu_a ^ alu_b;
      4'd5: alu_res = alu_a >> alu_b;
      4'd6: alu_res = alu_a << alu_b;
      4'd7: alu_res = (alu_b != 0) ? alu_a % alu_b : '0;
      4'd8: alu_res = alu_a * alu_b;
      4'd9: alu_res = (alu_b != 0) ? alu_a / alu_b : '0;
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv_a(input logic v, input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    a_valid = v; a_op = op; a_x = x; a_y = y;
  endtask

  task automatic drv_b(input logic v, input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    b_valid = v; b_op = op; b_x = x; b_y = y;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_a(1'b1, 4'd0, 4'd1, 4'd1);
    drv_b(1'b1, 4'd0, 4'd1, 4'd1);
    #12;
    // reset state
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_err", res_err, 0);
    drv_a(1'b0, 0, 0, 0);
    drv_b(1'b0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: A ADD 3,4
    drv_a(1'b1, 4'd0, 4'd3, 4'd4); #1;
    chk("s1_a_ready", a_ready, 1);
    chk("s1_b_ready", b_ready, 0);
    step(); drv_a(1'b0, 0, 0, 0);
    chk("s1_alu_sel", alu_sel, 4'b0000);
    chk("s1_alu_a", alu_a, 3);
    chk("s1_alu_b", alu_b, 4);
    chk("s1_early_valid", res_valid, 0);
    step();
    chk("s1_res_valid", res_valid, 1);
    chk("s1_res_id", res_id, 0);
    chk("s1_res_y", res_y, 7);
    chk("s1_res_err", res_err, 0);
    step();
    chk("s1_pulse_end", res_valid, 0);

    // 3: B MULT 3,5 (puts last_grant at B for the contest below)
    drv_b(1'b1, 4'd8, 4'd3, 4'd5); #1;
    chk("s3_b_ready", b_ready, 1);
    chk("s3_a_ready", a_ready, 0);
    step(); drv_b(1'b0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("s3_alu_sel_t%0d", i), alu_sel, 4'b1000);
      chk($sformatf("s3_no_valid_t%0d", i), res_valid, 0);
      step();
    end
    chk("s3_res_valid", res_valid, 1);
    chk("s3_res_id", res_id, 1);
    chk("s3_res_y", res_y, 15);
    step();

    // 2: A SUB 9,2 and B XOR 5,3 together
    drv_a(1'b1, 4'd1, 4'd9, 4'd2);
    drv_b(1'b1, 4'd4, 4'd5, 4'd3); #1;
    chk("s2_a_ready", a_ready, 1);
    chk("s2_b_ready", b_ready, 0);
    step(); drv_a(1'b0, 0, 0, 0);
    chk("s2_b_wait1", b_ready, 0);
    step();
    chk("s2_a_valid", res_valid, 1);
    chk("s2_a_id", res_id, 0);
    chk("s2_a_y", res_y, 7);
    chk("s2_b_wait2", b_ready, 0);
    step();
    chk("s2_b_ready_t3", b_ready, 1);
    step(); drv_b(1'b0, 0, 0, 0);
    step();
    chk("s2_b_valid", res_valid, 1);
    chk("s2_b_id", res_id, 1);
    chk("s2_b_y", res_y, 6);
    step();
    drv_a(1'b1, 4'd2, 4'd6, 4'd3);
    drv_b(1'b1, 4'd3, 4'd4, 4'd1); #1;
    chk("s2_again_a", a_ready, 1);
    chk("s2_again_b", b_ready, 0);
    step(); drv_a(1'b0, 0, 0, 0); drv_b(1'b0, 0, 0, 0);
    step();
    chk("s2_and_y", res_y, 2);
    chk("s2_and_id", res_id, 0);
    step();

    // 4: illegal opcode, then DIV by zero
    drv_a(1'b1, 4'b1100, 4'd1, 4'd1); #1;
    chk("s4_ill_ready", a_ready, 1);
    step(); drv_a(1'b0, 0, 0, 0);
    chk("s4_ill_valid", res_valid, 1);
    chk("s4_ill_err", res_err, 1);
    chk("s4_ill_y", res_y, 0);
    chk("s4_ill_sel", alu_sel, 4'd2);
    step();
    chk("s4_ill_idle", res_valid, 0);
    drv_a(1'b1, 4'd9, 4'd8, 4'd0); #1;
    chk("s4_div0_ready", a_ready, 1);
    step(); drv_a(1'b0, 0, 0, 0);
    chk("s4_div0_valid", res_valid, 1);
    chk("s4_div0_err", res_err, 1);
    chk("s4_div0_y", res_y, 0);
    chk("s4_div0_sel", alu_sel, 4'd2);
    chk("s4_div0_a", alu_a, 6);
    step();

    // 6: B waits through A MOD 7,3; B operands change while waiting
    drv_a(1'b1, 4'd7, 4'd7, 4'd3); #1;
    chk("s6_a_ready", a_ready, 1);
    step(); drv_a(1'b0, 0, 0, 0);
    drv_b(1'b1, 4'd0, 4'd1, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("s6_b_wait_t%0d", i), b_ready, 0);
      step();
      b_x = 4'(i + 4); b_y = 4'(i + 5);
    end
    #1;
    chk("s6_mod_valid", res_valid, 1);
    chk("s6_mod_y", res_y, 1);
    chk("s6_mod_err", res_err, 0);
    chk("s6_b_wait_resp", b_ready, 0);
    step();
    b_x = 4'd2; b_y = 4'd3; #1;
    chk("s6_b_ready", b_ready, 1);
    step(); drv_b(1'b0, 0, 0, 0);
    chk("s6_b_alu_a", alu_a, 2);
    chk("s6_b_alu_b", alu_b, 3);
    step();
    chk("s6_b_valid", res_valid, 1);
    chk("s6_b_id", res_id, 1);
    chk("s6_b_y", res_y, 5);
    step();

    // 5: B DIV 12,3 aborted by reset at t+2
    drv_b(1'b1, 4'd9, 4'd12, 4'd3); #1;
    chk("s5_b_ready", b_ready, 1);
    step(); drv_b(1'b0, 0, 0, 0);
    chk("s5_alu_sel", alu_sel, 4'd9);
    step();
    rst_n = 1'b0; #1;
    chk("s5_rst_sel", alu_sel, 0);
    chk("s5_rst_a", alu_a, 0);
    chk("s5_rst_b", alu_b, 0);
    chk("s5_rst_valid", res_valid, 0);
    chk("s5_rst_y", res_y, 0);
    chk("s5_rst_id", res_id, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("s5_no_valid_%0d", i), res_valid, 0);
      step();
    end
    drv_a(1'b1, 4'd0, 4'd1, 4'd1);
    drv_b(1'b1, 4'd0, 4'd2, 4'd2); #1;
    chk("s5_post_a", a_ready, 1);
    chk("s5_post_b", b_ready, 0);
    step(); drv_a(1'b0, 0, 0, 0); drv_b(1'b0, 0, 0, 0);
    step();
    chk("s5_post_y", res_y, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares the single combinational ALU datapath (the 10-way operation select: ADD, SUB, AND, OR, XOR, LSR, LSL, MOD, MULT, DIV) between two requesters, A and B.
- Each requester presents an operation over a valid/ready handshake.
- The scheduler arbitrates round-robin and drives the ALU select and operands.
- It holds them for the op's latency (1 cycle for logic/add/shift, MULTI_LAT cycles for MOD/MULT/DIV) and returns a tagged result.
- Illegal opcodes and divide/modulo by zero are rejected without touching the ALU.

## Interface
- N, 4, operand/result width
- MULTI_LAT, 4, EXEC cycles for MOD/MULT/DIV (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid / b_valid  in  1  requester has an op pending
- a_ready / b_ready  out  1  op accepted this cycle (combinational)
- a_op / b_op  in  4  opcode, 0..9 legal
- a_x, a_y / b_x, b_y  in  N  operands
- alu_sel  out  4  ALU select
- alu_a, alu_b  out  N  ALU operands
- alu_res  in  N  ALU combinational result
- res_valid  out  1  one-cycle result pulse, no backpressure
- res_id  out  1  0 = A, 1 = B
- res_y  out  N  result
- res_err  out  1  illegal opcode or MOD/DIV with zero divisor

## Operation
States: IDLE, EXEC, RESP.

- **IDLE**
  - Grant rule: if exactly one valid, grant it. If both valid, grant the requester not in last_grant. last_grant resets to B, so A wins the first contest.
  - ready is asserted only in IDLE, for the granted requester only. Handshake = valid & ready.
  - On handshake, latch op, x, y and id, and update last_grant.
  - op > 9, or (op ∈ {MOD, DIV} and y == 0): set err, y_reg = 0, go to RESP.
  - op ∈ {MOD, MULT, DIV}: cnt = MULTI_LAT-1, go to EXEC.
  - Otherwise: cnt = 0, go to EXEC.
- **EXEC**
  - alu_sel/alu_a/alu_b are driven from the latched registers and held stable.
  - cnt decrements each cycle.
  - When cnt == 0: capture alu_res into y_reg and go to RESP.
- **RESP**
  - res_valid = 1, with res_id/res_y/res_err from registers.
  - Always goes to IDLE. No accept occurs in RESP.
- Outside EXEC, alu_sel/alu_a/alu_b hold the last latched values.
- A requester's valid held while busy sees ready = 0. Its operands are sampled only at handshake.
- Widths: result is the ALU's N bits. MULT truncation is the datapath's concern.

## Timing
- **Reset values:** state IDLE, a_ready = b_ready = 0 (while rst_n low), alu_sel = 0, alu_a = alu_b = 0, res_valid = 0, res_id = 0, res_y = 0, res_err = 0, last_grant = B, cnt = 0.
- **Latency** (handshake at cycle t, res_valid at):
  - single-cycle ops: t+2
  - MOD/MULT/DIV: t+MULTI_LAT+1
  - rejected op: t+1
- **Occupancy** (cycles from handshake until the next possible handshake): single op 3, multi op MULTI_LAT+2, rejected op 2.
- **Simultaneous requests:** exactly one grant per IDLE cycle. The loser keeps valid and is granted at the next IDLE.
- **Reset mid-EXEC or mid-RESP:** immediate abort. No res_valid is produced for the aborted op, and the next contest after release goes to A.

## Structure
- Package alu_ops_pkg:
  - opcode constants OP_ADD = 0 … OP_DIV = 9, in the datapath's select order
  - state enum {IDLE, EXEC, RESP}
  - function is_multicycle(op)
  - function is_legal(op)
- Sub-module rr_arbiter2: 2-way round-robin with last_grant register, inputs req[1:0] and en, output one-hot gnt[1:0].
- Everything else lives in alu_scheduler: FSM, counter, operand/result registers.

## Test plan
All scenarios use N = 4, MULTI_LAT = 4, with the bench modelling the ALU behaviourally.
1. A only, ADD x=3 y=4 → a_ready at t, alu_sel = 0000 at t+1, res_valid at t+2 with res_id = 0, res_y = 7, res_err = 0.
2. A SUB 9,2 and B XOR 5,3 raised in the same cycle:
   - A granted first: res_y = 7 at t+2.
   - B granted at t+3: res_y = 6 at t+5, res_id = 1.
   - Both valid again: A granted.
3. B MULT x=3 y=5 → alu_sel = 1000 stable for cycles t+1..t+4, res_valid at t+5 with res_y = 15.
4. A op = 1100 → res_valid at t+1, res_err = 1, res_y = 0, alu_sel unchanged. Then A DIV 8,0 → res_err = 1 at t+1.
5. B DIV 12,3 with rst_n pulsed low at t+2 → all outputs at reset values immediately, no res_valid afterwards. After release, A and B both valid → A granted.
6. B valid held through A's MOD 7,3 → b_ready = 0 until IDLE. The B operands change mid-wait; only the values present at b's handshake are used.
